// File: rtl/conversor_bcd_serial.sv
// Sequential signed-binary to packed BCD converter, one shift-and-add-3 step per clock.
// Define QUEBRA_SUPRIME_ZEROS_EN to blank leading zero digits with 4'hF.
module conversor_bcd_serial #(
    parameter int LARGURA = 32,
    parameter int DIGITOS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LARGURA-1:0]   entrada,
    input  logic                 inicio,
    output logic                 ocupado,
    output logic                 pronto,
    output logic                 negativo,
    output logic                 estouro,
    output logic [4*DIGITOS-1:0] bcd
);
    localparam int CW = $clog2(LARGURA + 1);
    localparam int BW = 4 * DIGITOS;

    typedef enum logic {OCIOSO, CONVERTE} estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] mag_q, mag_d;
    logic [BW-1:0]      desloc_q, desloc_d;
    logic [CW-1:0]      cont_q, cont_d;
    logic               sinal_q, sinal_d;
    logic               ovf_q, ovf_d;
    logic               ocupado_q, ocupado_d;
    logic               pronto_q, pronto_d;
    logic               negativo_q, negativo_d;
    logic               estouro_q, estouro_d;
    logic [BW-1:0]      bcd_q, bcd_d;

    logic [BW-1:0]      corrigido;
    logic [BW-1:0]      passo;
    logic [BW-1:0]      final_bcd;
    logic               carry;
    logic               ultimo;

    // One double-dabble step: correct digits >= 5, then shift in the next magnitude bit.
    always_comb begin
        corrigido = desloc_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (desloc_q[4*i +: 4] >= 4'd5) begin
                corrigido[4*i +: 4] = desloc_q[4*i +: 4] + 4'd3;
            end
        end
        passo  = {corrigido[BW-2:0], mag_q[LARGURA-1]};
        carry  = corrigido[BW-1];
        ultimo = (cont_q == CW'(LARGURA - 1));
    end

`ifdef QUEBRA_SUPRIME_ZEROS_EN
    logic visto;

    // Digits above the most significant non-zero digit become blank; units always shown.
    always_comb begin
        final_bcd = passo;
        visto     = 1'b0;
        for (int i = DIGITOS - 1; i > 0; i--) begin
            if (passo[4*i +: 4] != 4'd0) begin
                visto = 1'b1;
            end
            if (!visto) begin
                final_bcd[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    always_comb begin
        final_bcd = passo;
    end
`endif

    always_comb begin
        estado_d   = estado_q;
        mag_d      = mag_q;
        desloc_d   = desloc_q;
        cont_d     = cont_q;
        sinal_d    = sinal_q;
        ovf_d      = ovf_q;
        ocupado_d  = ocupado_q;
        pronto_d   = 1'b0;
        negativo_d = negativo_q;
        estouro_d  = estouro_q;
        bcd_d      = bcd_q;
        if (estado_q == OCIOSO) begin
            if (inicio) begin
                // The most negative value negates to itself, which is the correct unsigned magnitude.
                mag_d     = entrada[LARGURA-1] ? (~entrada) + LARGURA'(1) : entrada;
                sinal_d   = entrada[LARGURA-1];
                desloc_d  = '0;
                cont_d    = '0;
                ovf_d     = 1'b0;
                ocupado_d = 1'b1;
                estado_d  = CONVERTE;
            end
        end else begin
            mag_d    = {mag_q[LARGURA-2:0], 1'b0};
            desloc_d = passo;
            ovf_d    = ovf_q | carry;
            cont_d   = cont_q + CW'(1);
            if (ultimo) begin
                bcd_d      = final_bcd;
                negativo_d = sinal_q;
                estouro_d  = ovf_q | carry;
                pronto_d   = 1'b1;
                ocupado_d  = 1'b0;
                estado_d   = OCIOSO;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            mag_q      <= '0;
            desloc_q   <= '0;
            cont_q     <= '0;
            sinal_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            negativo_q <= 1'b0;
            estouro_q  <= 1'b0;
            bcd_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            mag_q      <= mag_d;
            desloc_q   <= desloc_d;
            cont_q     <= cont_d;
            sinal_q    <= sinal_d;
            ovf_q      <= ovf_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
            negativo_q <= negativo_d;
            estouro_q  <= estouro_d;
            bcd_q      <= bcd_d;
        end
    end

    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;
    assign negativo = negativo_q;
    assign estouro  = estouro_q;
    assign bcd      = bcd_q;

endmodule

// File: tb/tb_conversor_bcd_serial.sv
// Self-checking bench for conversor_bcd_serial: two instances (32/10 and 16/3) against an arithmetic model.
module tb_conversor_bcd_serial;
    logic        clock;
    logic        reset;
    logic [31:0] entrada_a;
    logic        inicio_a;
    logic        ocupado_a, pronto_a, negativo_a, estouro_a;
    logic [39:0] bcd_a;
    logic [15:0] entrada_b;
    logic        inicio_b;
    logic        ocupado_b, pronto_b, negativo_b, estouro_b;
    logic [11:0] bcd_b;

    int n_checks = 0;
    int n_errors = 0;

    conversor_bcd_serial #(.LARGURA(32), .DIGITOS(10)) dut_a (
        .clock(clock), .reset(reset), .entrada(entrada_a), .inicio(inicio_a),
        .ocupado(ocupado_a), .pronto(pronto_a), .negativo(negativo_a),
        .estouro(estouro_a), .bcd(bcd_a)
    );

    conversor_bcd_serial #(.LARGURA(16), .DIGITOS(3)) dut_b (
        .clock(clock), .reset(reset), .entrada(entrada_b), .inicio(inicio_b),
        .ocupado(ocupado_b), .pronto(pronto_b), .negativo(negativo_b),
        .estouro(estouro_b), .bcd(bcd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint unsigned ref_mag(input logic [63:0] val, input int l);
        longint unsigned m, mask;
        mask = (l >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << l) - 64'd1);
        m = val & mask;
        if (val[l-1]) m = (64'd0 - m) & mask;
        return m;
    endfunction

    function automatic longint unsigned ref_pow(input int d);
        longint unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic ref_ovf(input logic [63:0] val, input int l, input int d);
        return ref_mag(val, l) >= ref_pow(d);
    endfunction

    // Decimal digits of the magnitude modulo 10^d, leading digits blanked in the blanking build.
    function automatic logic [79:0] ref_bcd(input logic [63:0] val, input int l, input int d);
        longint unsigned m, t;
        logic [79:0] r;
        int nd;
        m = ref_mag(val, l) % ref_pow(d);
        t = m;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        nd = 1;
        t = m / 10;
        while (t != 0) begin
            nd++;
            t = t / 10;
        end
`ifdef QUEBRA_SUPRIME_ZEROS_EN
        for (int i = nd; i < d; i++) r[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Cycle-level behavioural model: a busy countdown plus an arithmetically computed pending result.
    logic        model_valid = 1'b0;
    int          rem_a = 0, rem_b = 0;
    logic [79:0] pend_bcd_a, pend_bcd_b, exp_bcd_a, exp_bcd_b;
    logic        pend_neg_a, pend_neg_b, pend_ovf_a, pend_ovf_b;
    logic        exp_neg_a, exp_neg_b, exp_ovf_a, exp_ovf_b, exp_pronto_a, exp_pronto_b;

    always @(posedge clock) begin
        if (reset) begin
            model_valid  <= 1'b1;
            rem_a        <= 0;
            exp_bcd_a    <= '0;
            exp_neg_a    <= 1'b0;
            exp_ovf_a    <= 1'b0;
            exp_pronto_a <= 1'b0;
        end else begin
            exp_pronto_a <= 1'b0;
            if (rem_a != 0) begin
                rem_a <= rem_a - 1;
                if (rem_a == 1) begin
                    exp_bcd_a    <= pend_bcd_a;
                    exp_neg_a    <= pend_neg_a;
                    exp_ovf_a    <= pend_ovf_a;
                    exp_pronto_a <= 1'b1;
                end
            end else if (inicio_a) begin
                rem_a      <= 32;
                pend_bcd_a <= ref_bcd({32'b0, entrada_a}, 32, 10);
                pend_neg_a <= entrada_a[31];
                pend_ovf_a <= ref_ovf({32'b0, entrada_a}, 32, 10);
            end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            rem_b        <= 0;
            exp_bcd_b    <= '0;
            exp_neg_b    <= 1'b0;
            exp_ovf_b    <= 1'b0;
            exp_pronto_b <= 1'b0;
        end else begin
            exp_pronto_b <= 1'b0;
            if (rem_b != 0) begin
                rem_b <= rem_b - 1;
                if (rem_b == 1) begin
                    exp_bcd_b    <= pend_bcd_b;
                    exp_neg_b    <= pend_neg_b;
                    exp_ovf_b    <= pend_ovf_b;
                    exp_pronto_b <= 1'b1;
                end
            end else if (inicio_b) begin
                rem_b      <= 16;
                pend_bcd_b <= ref_bcd({48'b0, entrada_b}, 16, 3);
                pend_neg_b <= entrada_b[15];
                pend_ovf_b <= ref_ovf({48'b0, entrada_b}, 16, 3);
            end
        end
    end

    // Every cycle once the model is anchored by reset, all outputs of both instances are compared.
    always @(negedge clock) begin
        if (model_valid) begin
            checkOutput("a_ocupado",  {79'b0, ocupado_a},  {79'b0, rem_a != 0});
            checkOutput("a_pronto",   {79'b0, pronto_a},   {79'b0, exp_pronto_a});
            checkOutput("a_negativo", {79'b0, negativo_a}, {79'b0, exp_neg_a});
            checkOutput("a_estouro",  {79'b0, estouro_a},  {79'b0, exp_ovf_a});
            checkOutput("a_bcd",      {40'b0, bcd_a},      exp_bcd_a);
            checkOutput("b_ocupado",  {79'b0, ocupado_b},  {79'b0, rem_b != 0});
            checkOutput("b_pronto",   {79'b0, pronto_b},   {79'b0, exp_pronto_b});
            checkOutput("b_negativo", {79'b0, negativo_b}, {79'b0, exp_neg_b});
            checkOutput("b_estouro",  {79'b0, estouro_b},  {79'b0, exp_ovf_b});
            checkOutput("b_bcd",      {68'b0, bcd_b},      exp_bcd_b);
        end
    end

    task automatic applyStimulus(input bit sel, input logic [31:0] val);
        @(posedge clock);
        #1;
        if (sel) begin
            entrada_b = val[15:0];
            inicio_b  = 1'b1;
        end else begin
            entrada_a = val;
            inicio_a  = 1'b1;
        end
        @(posedge clock);
        #1;
        inicio_a = 1'b0;
        inicio_b = 1'b0;
    endtask

    task automatic wait_pronto(input bit sel, output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clock);
            if (sel ? pronto_b : pronto_a) return;
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic convert(input bit sel, input logic [31:0] val, input logic [79:0] e_bcd,
                           input logic e_neg, input logic e_ovf, input string name);
        int cyc;
        applyStimulus(sel, val);
        wait_pronto(sel, cyc);
        checkOutput({name, "_latency"}, 80'(cyc), sel ? 80'd16 : 80'd32);
        checkOutput({name, "_bcd"}, sel ? {68'b0, bcd_b} : {40'b0, bcd_a}, e_bcd);
        checkOutput({name, "_neg"}, {79'b0, sel ? negativo_b : negativo_a}, {79'b0, e_neg});
        checkOutput({name, "_ovf"}, {79'b0, sel ? estouro_b : estouro_a}, {79'b0, e_ovf});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int marks[$];
        reset = 1'b1;
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        entrada_a = '0;
        entrada_b = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        checkOutput("reset_bcd_a", {40'b0, bcd_a}, 80'h0);
        checkOutput("reset_ocupado_a", {79'b0, ocupado_a}, 80'h0);
        checkOutput("pin_model_neg123", ref_bcd(64'hFFFF_FF85, 32, 10),
`ifdef QUEBRA_SUPRIME_ZEROS_EN
                    80'hFFFFFFF123);
`else
                    80'h123);
`endif
        checkOutput("pin_model_ovf1000", {79'b0, ref_ovf(64'd1000, 16, 3)}, 80'h1);

        convert(1'b0, 32'h0000_0000, 80'h0, 1'b0, 1'b0, "zero");
`ifdef QUEBRA_SUPRIME_ZEROS_EN
        convert(1'b0, 32'hFFFF_FF85, 80'hFFFFFFF123, 1'b1, 1'b0, "neg123");
        convert(1'b1, 32'd1000, 80'hFF0, 1'b0, 1'b1, "b_1000");
`else
        convert(1'b0, 32'hFFFF_FF85, 80'h123, 1'b1, 1'b0, "neg123");
        convert(1'b1, 32'd1000, 80'h000, 1'b0, 1'b1, "b_1000");
`endif
        convert(1'b0, 32'h8000_0000, 80'h2147483648, 1'b1, 1'b0, "most_neg");
        convert(1'b1, 32'd999, 80'h999, 1'b0, 1'b0, "b_999");

        // inicio and entrada changes mid-conversion are ignored.
        applyStimulus(1'b0, 32'd12345);
        repeat (10) @(posedge clock);
        #1 entrada_a = 32'd777;
        inicio_a = 1'b1;
        @(posedge clock);
        #1 inicio_a = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (pronto_a) pulses++;
        end
        checkOutput("midconv_pulses", 80'(pulses), 80'd1);
`ifdef QUEBRA_SUPRIME_ZEROS_EN
        checkOutput("midconv_bcd", {40'b0, bcd_a}, 80'hFFFFF12345);
`else
        checkOutput("midconv_bcd", {40'b0, bcd_a}, 80'h12345);
`endif

        // Reset mid-conversion aborts without pronto and clears every output.
        applyStimulus(1'b0, 32'hFFFF_CFC7);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (pronto_a) pulses++;
        end
        checkOutput("abort_pulses", 80'(pulses), 80'd0);
        checkOutput("abort_bcd", {40'b0, bcd_a}, 80'h0);
        checkOutput("abort_neg", {79'b0, negativo_a}, 80'h0);
        checkOutput("abort_ocupado", {79'b0, ocupado_a}, 80'h0);
`ifdef QUEBRA_SUPRIME_ZEROS_EN
        convert(1'b0, 32'd12345, 80'hFFFFF12345, 1'b0, 1'b0, "after_abort");
`else
        convert(1'b0, 32'd12345, 80'h12345, 1'b0, 1'b0, "after_abort");
`endif

        // inicio held high with alternating 7 / -7: one conversion every 33 clocks.
        @(posedge clock);
        #1;
        for (int i = 0; i < 100; i++) begin
            entrada_a = (i % 2 == 0) ? 32'd7 : 32'hFFFF_FFF9;
            inicio_a = 1'b1;
            @(negedge clock);
            if (pronto_a) begin
                checkOutput("b2b_neg", {79'b0, negativo_a}, {79'b0, marks.size() % 2 == 1});
                marks.push_back(i);
            end
            @(posedge clock);
            #1;
        end
        inicio_a = 1'b0;
        checkOutput("b2b_count", 80'(marks.size()), 80'd3);
        for (int k = 1; k < marks.size(); k++) begin
            checkOutput("b2b_period", 80'(marks[k] - marks[k-1]), 80'd33);
        end
        repeat (40) @(posedge clock);

        // Randomised traffic on both instances, including occasional resets.
        for (int i = 0; i < 2500; i++) begin
            #1;
            case ($urandom_range(0, 7))
                0: entrada_a = 32'h0;
                1: entrada_a = 32'h8000_0000;
                2: entrada_a = 32'd0 - 32'($urandom_range(0, 5000));
                default: entrada_a = $urandom();
            endcase
            entrada_b = 16'($urandom());
            inicio_a = ($urandom_range(0, 3) == 0);
            inicio_b = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            @(posedge clock);
        end
        #1;
        reset = 1'b0;
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        repeat (40) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
